// File: rtl/outarb_pkg.sv
// Switch-wide widths and flit flow codes shared by the arbiter, picker and bench.
// Mirrors the switch's common definitions so this slice stands alone.
package outarb_pkg;
    localparam int PORT   = 3;
    localparam int NPORT  = PORT + 1;
    localparam int PKTW   = 9;
    localparam int FLOWBH = 9;
    localparam int FLOWBL = 8;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b01;
    localparam logic [1:0] HEAD = 2'b10;
endpackage

// File: rtl/outarb_rrpick.sv
// Combinational 4-way round-robin picker: first set request at or above prio, wrapping.
module outarb_rrpick
    import outarb_pkg::*;
(
    input  logic [PORT:0] req_i,
    input  logic [1:0]    prio_i,
    output logic [PORT:0] gnt_o,
    output logic [1:0]    idx_o
);
    logic       found;
    logic [1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = prio_i + 2'(k);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end
endmodule

// File: rtl/outarb.sv
// Per-output arbiter: grants one input per packet, holds it HEAD..TAIL, rotates priority.
module outarb
    import outarb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [PORT:0] req,
    input  logic [PKTW:0] pkt,
    input  logic          full,
    output logic [PORT:0] ack,
    output logic [1:0]    sel,
    output logic          busy
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PORT:0] ack_q, ack_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    prio_q, prio_d;
    logic          busy_q, busy_d;

    logic [PORT:0] pick_gnt;
    logic [1:0]    pick_idx;
    logic          tail_xfer;
    logic          unused_pkt;

    assign unused_pkt = ^pkt[FLOWBL-1:0];
    assign tail_xfer  = (pkt[FLOWBH:FLOWBL] == TAIL) && !full;

    outarb_rrpick u_pick (
        .req_i  (req),
        .prio_i (prio_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (|req && !full) begin
                    ack_d   = pick_gnt;
                    sel_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Requests are ignored until the packet's TAIL actually moves.
                if (tail_xfer) begin
                    ack_d   = '0;
                    sel_d   = '0;
                    prio_d  = sel_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = |ack_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            sel_q   <= '0;
            prio_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            busy_q  <= busy_d;
        end
    end

    assign ack  = ack_q;
    assign sel  = sel_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_outarb.sv
// Directed plus random bench for outarb against a packet-level ownership model.
module tb_outarb;
    import outarb_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PORT:0] req = '0;
    logic [PKTW:0] pkt = '0;
    logic          full = 1'b0;
    logic [PORT:0] ack;
    logic [1:0]    sel;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int owner = -1;
    int mprio = 0;

    outarb dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .pkt  (pkt),
        .full (full),
        .ack  (ack),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ack"},  32'(ack),  (owner < 0) ? 32'd0 : (32'd1 << owner));
        chk({tag, ".sel"},  32'(sel),  (owner < 0) ? 32'd0 : 32'(owner));
        chk({tag, ".busy"}, 32'(busy), (owner < 0) ? 32'd0 : 32'd1);
    endtask

    task automatic set_flow(input logic [1:0] f);
        pkt = {f, 8'($urandom)};
    endtask

    // Advance one edge, update the model from the inputs that edge saw, then check.
    task automatic cyc(input string tag);
        logic [PORT:0] r;
        logic          fu;
        logic [1:0]    fl;
        @(posedge clk);
        r  = req;
        fu = full;
        fl = pkt[FLOWBH:FLOWBL];
        if (!rst) begin
            owner = -1;
            mprio = 0;
        end else if (owner < 0) begin
            if (r != 0 && !fu) begin
                for (int j = NPORT - 1; j >= 0; j--)
                    if (r[(mprio + j) % NPORT]) owner = (mprio + j) % NPORT;
            end
        end else if (fl == TAIL && !fu) begin
            mprio = (owner + 1) % NPORT;
            owner = -1;
        end
        #1;
        chk_model(tag);
    endtask

    initial begin
        logic [PORT:0] rr_exp [5];
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        set_flow(BODY);
        cyc("reset");
        cyc("reset2");
        rst = 1'b1;

        // Single request, HEAD/BODY/TAIL.
        req = 4'b0100;
        cyc("single.grant");
        chk("single.ack", 32'(ack), 32'h4);
        req = '0;
        set_flow(HEAD); cyc("single.head");
        set_flow(BODY); cyc("single.body");
        set_flow(TAIL); cyc("single.tail");
        chk("single.rel", 32'(ack), 32'h0);

        // Reset mid-packet acts without a clock edge.
        req = 4'b0100; set_flow(BODY);
        cyc("mid.grant");
        req = '0; set_flow(HEAD);
        cyc("mid.head");
        #2 rst = 1'b0;
        #1;
        owner = -1; mprio = 0;
        chk_model("mid.async");
        #3 rst = 1'b1;
        req = 4'b0011; set_flow(BODY);
        cyc("mid.regrant");
        chk("mid.prio0", 32'(ack), 32'h1);
        req = '0; set_flow(TAIL);
        cyc("mid.tail");

        // Round robin with all requesting and 2-flit packets.
        req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            set_flow(BODY);
            cyc("rr.grant");
            chk("rr.order", 32'(ack), 32'(rr_exp[p]));
            set_flow(HEAD); cyc("rr.head");
            set_flow(TAIL); cyc("rr.tail");
            chk("rr.gap", 32'(ack), 32'h0);
        end

        // Wrap: release port 2 -> prio 3.
        req = 4'b0100; set_flow(BODY); cyc("wrap.g2");
        set_flow(TAIL); cyc("wrap.t2");
        req = 4'b0011; set_flow(BODY); cyc("wrap.g0");
        chk("wrap.ack0", 32'(ack), 32'h1);
        set_flow(TAIL); cyc("wrap.t0");
        req = 4'b1001; set_flow(BODY); cyc("wrap.g3");
        chk("wrap.ack3", 32'(ack), 32'h8);
        set_flow(TAIL); cyc("wrap.t3");

        // Backpressure on TAIL, then in IDLE.
        req = 4'b0010; set_flow(BODY); cyc("bp.grant");
        set_flow(HEAD); cyc("bp.head");
        set_flow(TAIL); full = 1'b1;
        for (int i = 0; i < 3; i++) cyc("bp.hold");
        chk("bp.held", 32'(ack), 32'h2);
        full = 1'b0; cyc("bp.rel");
        full = 1'b1; req = 4'b0010; set_flow(BODY);
        for (int i = 0; i < 3; i++) cyc("bp.idle");
        chk("bp.nogrant", 32'(ack), 32'h0);
        full = 1'b0; cyc("bp.grant2");
        chk("bp.ack1", 32'(ack), 32'h2);

        // Request noise while port 1 owns the output.
        req = 4'b1000; set_flow(HEAD); cyc("noise.a");
        req = 4'b0000; set_flow(BODY); cyc("noise.b");
        req = 4'b1000; cyc("noise.c");
        chk("noise.held", 32'(ack), 32'h2);
        set_flow(TAIL); cyc("noise.tail");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req  = 4'($urandom);
            full = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: set_flow(HEAD);
                1: set_flow(BODY);
                default: set_flow(TAIL);
            endcase
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/outarb.md
# outarb

Per-output-port arbiter of the 4-port packet switch; the responder to the request generators in front of each input FIFO. It collects the request bit for its output port from all four inputs, grants one input per packet with round-robin fairness, and holds the grant from the HEAD flit through the TAIL flit. The one-hot grant drives the crossbar select and the dequeue of the winning input FIFO. The switch instantiates one `outarb` per output port.

## Interface
- No parameters; widths come from `sw.vh` (`PORT`=3, `PKTW`, `FLOWBH`/`FLOWBL`).
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — reset, asynchronous and active-low.
- `req`  in  [`PORT:0]  — bit i set: input i's head flit requests this output (registered request from input i's request generator).
- `pkt`  in  [`PKTW:0]  — flit currently switched onto this output (crossbar output); flow code in [`FLOWBH:`FLOWBL].
- `full`  in  1  — downstream buffer full; no flit transfers and no new grants while high.
- `ack`  out  [`PORT:0]  — one-hot grant / crossbar select; all-zero when idle.
- `sel`  out  [1:0]  — binary index of the granted input; 0 when idle.
- `busy`  out  1  — packet in flight (`ack` != 0).

## Operation
- Flow codes come from `sw.vh`: `HEAD`, `BODY`, `TAIL`. A packet is HEAD, then zero or more BODY flits, then TAIL, with at least 2 flits.
- A flit transfers on a cycle with `busy`=1 and `full`=0.
- State `IDLE`:
  - If `req`!=0 and `full`=0, pick the first set bit scanning from `prio` upward, mod 4.
  - Register `ack`=onehot(winner) and `sel`=winner, then go to `GRANT`.
  - Otherwise stay idle with `ack`=0.
- State `GRANT`:
  - `ack` and `sel` hold.
  - `req` is ignored entirely, including new requests and any bit dropping.
  - When `pkt` flow = `TAIL` and `full`=0, clear `ack`/`sel` to 0, set `prio`=winner+1 (2-bit wrap, 3→0), and go to `IDLE`.
  - A TAIL seen while `full`=1 is not a transfer and does not release the grant.
- `prio` is a 2-bit pointer with reset value 0 and is updated only on release.
- `ack` is always one-hot or zero. `busy` = |`ack`.

## Timing
- Reset (`rst`=0, asynchronous) forces `ack`=0, `sel`=0, `busy`=0, `prio`=0 and state `IDLE` immediately, including mid-packet. The first grant comes at least one edge after deassertion.
- Grant latency: `req` sampled at edge k drives `ack` valid from just after edge k. `ack`, `sel` and `busy` are all registered outputs.
- Release: TAIL transferred at edge m drives `ack`=0 after edge m.
- Earliest re-grant is edge m+1, so there is one mandatory idle cycle between packets, even when requests are pending.
- `full` high at the arbitration edge: no grant; arbitration retries every cycle until `full`=0.
- Requests pending at release are served in rotated priority order. A port releasing its grant has lowest priority next round.

## Structure
- `HEAD`/`BODY`/`TAIL` codes, `PORT`, `PKTW` and `FLOWBH`/`FLOWBL` live in the shared `sw.vh`, not in this block. The state encoding (`IDLE`/`GRANT`) is local.
- One sub-module is natural: `rrpick`, a combinational 4-bit round-robin picker taking `req` and `prio` and returning the one-hot winner plus its index. It is reusable by future virtual-channel arbiters.

## Test plan
- Reset mid-packet: grant input 2, assert `rst`=0 between edges → `ack`=0000 and `sel`=0 immediately, without waiting for an edge. After release, `req`=0011 → `ack`=0001 (`prio` back to 0).
- Single request: `req`=0100 at edge k → `ack`=0100, `sel`=2, `busy`=1 after k. Drive HEAD, BODY, TAIL with `full`=0 → `ack`=0000 after the TAIL edge.
- Round robin: `req`=1111 held, 2-flit packets → grants in order 0001, 0010, 0100, 1000, 0001. Each grant is separated by one idle cycle.
- Wrap: `prio`=3 (after a port 2 release), `req`=0011 → grant 0001. After that release `prio`=1, and `req`=1001 → grant 1000.
- Backpressure: in `GRANT`, `pkt`=TAIL with `full`=1 for 3 cycles → `ack` held. `full`=0 → release after that edge. In `IDLE` with `full`=1, `req`=0010 → no grant until `full`=0.
- Request noise: while port 1 is granted, toggle `req` to 1000 and to 0000 → `ack` stays 0010 until TAIL.
